// File: rtl/tick_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_req_scheduler
// Purpose  : Checks that upstream ticks are evenly spaced and turns each tick
//            into a request credit issued over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tick_req_scheduler #(
    parameter int PERIOD   = 2501,
    parameter int CBITS    = 12,
    parameter int MAX_PEND = 4,
    parameter int PBITS    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [PBITS-1:0] pend,
    output logic             locked,
    output logic             early_err,
    output logic             late_err,
    output logic             drop_err
);

    localparam logic [CBITS-1:0] PERIOD_CNT = CBITS'(PERIOD);
    localparam logic [PBITS-1:0] PEND_LIMIT = PBITS'(MAX_PEND);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CBITS-1:0] icnt;
    logic [CBITS-1:0] icnt_next;
    logic             early_next;
    logic             late_next;
    logic [PBITS-1:0] pend_next;
    logic             drop_next;
    logic             accept;

    assign req_valid = (pend != '0);
    assign accept    = req_valid && req_ready;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            icnt      <= '0;
            pend      <= '0;
            early_err <= 1'b0;
            late_err  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= next_state;
            icnt      <= icnt_next;
            pend      <= pend_next;
            early_err <= early_next;
            late_err  <= late_next;
            drop_err  <= drop_next;
        end
    end

    // Interval tracking: icnt counts cycles since the last tick while locked.
    always_comb begin
        next_state = state;
        icnt_next  = icnt;
        early_next = 1'b0;
        late_next  = 1'b0;
        case (state)
            SEARCH: begin
                icnt_next = '0;
                if (tick) begin
                    next_state = LOCKED;
                    icnt_next  = CBITS'(1);
                end
            end
            LOCKED: begin
                if (tick) begin
                    // An early tick resyncs the interval rather than dropping lock.
                    icnt_next  = CBITS'(1);
                    early_next = (icnt != PERIOD_CNT);
                end else if (icnt == PERIOD_CNT) begin
                    next_state = SEARCH;
                    icnt_next  = '0;
                    late_next  = 1'b1;
                end else begin
                    icnt_next = icnt + CBITS'(1);
                end
            end
            default: begin
                next_state = SEARCH;
                icnt_next  = '0;
            end
        endcase
    end

    // Credit store: simultaneous enqueue and dequeue leave the count unchanged.
    always_comb begin
        pend_next = pend;
        drop_next = 1'b0;
        case ({tick, accept})
            2'b10: begin
                if (pend < PEND_LIMIT) begin
                    pend_next = pend + PBITS'(1);
                end else begin
                    drop_next = 1'b1;
                end
            end
            2'b01:   pend_next = pend - PBITS'(1);
            default: pend_next = pend;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_req_scheduler
// Purpose  : Directed self-checking bench for tick_req_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_req_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] pend;
    logic       locked;
    logic       early_err;
    logic       late_err;
    logic       drop_err;

    int checks;
    int errors;

    tick_req_scheduler #(
        .PERIOD   (5),
        .CBITS    (4),
        .MAX_PEND (2),
        .PBITS    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .pend      (pend),
        .locked    (locked),
        .early_err (early_err),
        .late_err  (late_err),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        tick      = 1'b0;
        req_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        tick      = 1'b0;
        req_ready = 1'b0;

        // Steady lock, consumer always ready
        do_reset();
        chk("rst_pend", 0, int'(pend), 0);
        chk("rst_valid", 0, int'(req_valid), 0);
        chk("rst_locked", 0, int'(locked), 0);
        chk("rst_errs", 0, int'({early_err, late_err, drop_err}), 0);
        for (int c = 0; c <= 14; c++) begin
            chk("s1_locked", c, int'(locked), int'(c >= 3));
            chk("s1_valid", c, int'(req_valid), int'(c == 3 || c == 8 || c == 13));
            chk("s1_errs", c, int'({early_err, late_err, drop_err}), 0);
            tick      = (c == 2 || c == 7 || c == 12);
            req_ready = 1'b1;
            step();
        end
        chk("s1_pend_end", 15, int'(pend), 0);

        // Early tick at 10
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            chk("s2_early", c, int'(early_err), int'(c == 11));
            chk("s2_late", c, int'(late_err), 0);
            chk("s2_locked", c, int'(locked), int'(c >= 3));
            tick      = (c == 2 || c == 7 || c == 10 || c == 15);
            req_ready = 1'b1;
            step();
        end

        // Missing tick: late at 8, relock from tick at 9
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            chk("s3_late", c, int'(late_err), int'(c == 8));
            chk("s3_early", c, int'(early_err), 0);
            chk("s3_locked", c, int'(locked), int'((c >= 3 && c <= 7) || c >= 10));
            tick      = (c == 2 || c == 9);
            req_ready = 1'b1;
            step();
        end

        // Store fills, tick at 12 dropped, then drains
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            int ep;
            if (c < 3)        ep = 0;
            else if (c <= 7)  ep = 1;
            else if (c <= 13) ep = 2;
            else if (c == 14) ep = 1;
            else              ep = 0;
            chk("s4_pend", c, int'(pend), ep);
            chk("s4_valid", c, int'(req_valid), int'(ep != 0));
            chk("s4_drop", c, int'(drop_err), int'(c == 13));
            tick      = (c == 2 || c == 7 || c == 12);
            req_ready = (c == 13 || c == 14);
            step();
        end

        // Full store with tick+accept, then mid-run reset and relock
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            int ep;
            if (c < 3)        ep = 0;
            else if (c <= 7)  ep = 1;
            else if (c <= 13) ep = 2;
            else if (c == 14) ep = 0;
            else              ep = 1;
            chk("s5_pend", c, int'(pend), ep);
            chk("s5_valid", c, int'(req_valid), int'(ep != 0));
            chk("s5_locked", c, int'(locked), int'((c >= 3 && c <= 13) || c >= 15));
            chk("s5_errs", c, int'({early_err, late_err, drop_err}), 0);
            tick      = (c == 2 || c == 7 || c == 12 || c == 14);
            req_ready = (c == 12);
            rst       = (c == 13);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
